// File: rtl/phy_tx_fifo_arbiter_pkg.sv
// Shared constants and types for the PHY-TX FIFO arbiter slice.
package l2sw_pkg;

  localparam int N_REQ    = 5;
  localparam int N_PORT   = 4;
  localparam int BYTE_W   = 8;
  localparam int REQ_CTRL = 4;
  localparam int OWN_W    = 3;

  typedef logic [OWN_W-1:0] owner_t;

  function automatic owner_t ptr_inc(input owner_t idx, input int n);
    return (int'(idx) >= n - 1) ? '0 : owner_t'(idx + 1'b1);
  endfunction

endpackage

// File: rtl/phy_tx_fifo_arbiter_rr.sv
// Combinational round-robin pick: first eligible requester at or after rr_ptr.
module rr_arbiter
  import l2sw_pkg::*;
#(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  winner,
  output logic          winner_valid
);

  always_comb begin
    int idx;
    idx          = 0;
    winner       = '0;
    winner_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(rr_ptr) + i) % N;
      if (!winner_valid && eligible[idx]) begin
        winner[idx]  = 1'b1;
        winner_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phy_tx_fifo_arbiter.sv
// Frame-granular lock arbiter between requesters and the PHY-TX FIFOs.
// Optional build macro PHY_TX_ARB_CTRL_PRIO_EN: control requester beats round-robin.
module phy_tx_fifo_arbiter #(
  parameter int N_REQ  = l2sw_pkg::N_REQ,
  parameter int N_PORT = l2sw_pkg::N_PORT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_REQ-1:0]                     req_valid,
  input  logic [N_REQ*N_PORT-1:0]              req_port,
  output logic [N_REQ-1:0]                     req_grant,
  input  logic [N_REQ*l2sw_pkg::BYTE_W-1:0]    req_din,
  input  logic [N_REQ-1:0]                     req_wren,
  input  logic [N_REQ-1:0]                     req_del,
  output logic [N_REQ-1:0]                     req_afull,
  output logic [N_PORT*l2sw_pkg::BYTE_W-1:0]   fifo_din,
  output logic [N_PORT-1:0]                    fifo_wren,
  output logic [N_PORT-1:0]                    fifo_del,
  input  logic [N_PORT-1:0]                    fifo_afull,
  output logic                                 err_abort
);
  import l2sw_pkg::*;

  localparam int CTRL_IDX = N_REQ - 1;

  logic [N_PORT-1:0] busy;
  owner_t            owner [N_PORT];
  owner_t            rr_ptr;

  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  rr_win;
  logic              rr_valid;
  logic [N_REQ-1:0]  win;
  logic              win_valid;
  logic              win_prio;
  owner_t            win_idx;
  logic [N_PORT-1:0] win_ports;
  logic [N_REQ-1:0]  rel;
  logic [N_REQ-1:0]  abort;
  logic [N_PORT-1:0] rel_ports;

  // Eligibility uses the pre-release busy map, so a port freed this cycle is
  // only offered to new requesters on the following edge.
  always_comb begin
    eligible = '0;
    rel      = '0;
    abort    = '0;
    for (int r = 0; r < N_REQ; r++) begin
      eligible[r] = req_valid[r] & ~req_grant[r]
                  & (|req_port[r*N_PORT +: N_PORT])
                  & ~(|(req_port[r*N_PORT +: N_PORT] & busy));
      abort[r]    = req_grant[r] & ~req_valid[r];
      rel[r]      = abort[r] | (req_grant[r] & req_wren[r] & req_del[r]);
    end
  end

  rr_arbiter #(
    .N  (N_REQ),
    .PW (OWN_W)
  ) u_rr (
    .eligible     (eligible),
    .rr_ptr       (rr_ptr),
    .winner       (rr_win),
    .winner_valid (rr_valid)
  );

  always_comb begin
    win       = rr_win;
    win_valid = rr_valid;
    win_prio  = 1'b0;
`ifdef PHY_TX_ARB_CTRL_PRIO_EN
    if (eligible[CTRL_IDX]) begin
      win           = '0;
      win[CTRL_IDX] = 1'b1;
      win_valid     = 1'b1;
      win_prio      = 1'b1;
    end
`endif
    win_idx   = '0;
    win_ports = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (win[r]) begin
        win_idx   = owner_t'(r);
        win_ports = req_port[r*N_PORT +: N_PORT];
      end
    end
  end

  // Owner table is the latched mask; req_port changes during a lock are ignored.
  always_comb begin
    rel_ports = '0;
    req_afull = '0;
    for (int p = 0; p < N_PORT; p++) begin
      if (busy[p]) begin
        rel_ports[p]         = rel[owner[p]];
        req_afull[owner[p]]  = req_afull[owner[p]] | fifo_afull[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= '0;
      rr_ptr    <= '0;
      req_grant <= '0;
      err_abort <= 1'b0;
      fifo_din  <= '0;
      fifo_wren <= '0;
      fifo_del  <= '0;
      for (int p = 0; p < N_PORT; p++) begin
        owner[p] <= '0;
      end
    end else begin
      busy      <= (busy & ~rel_ports) | win_ports;
      req_grant <= (req_grant & ~rel) | win;
      err_abort <= |abort;
      if (win_valid && !win_prio) begin
        rr_ptr <= ptr_inc(win_idx, N_REQ);
      end
      for (int p = 0; p < N_PORT; p++) begin
        if (win_ports[p]) begin
          owner[p] <= win_idx;
        end
        if (busy[p]) begin
          fifo_din[p*BYTE_W +: BYTE_W] <= req_din[int'(owner[p])*BYTE_W +: BYTE_W];
          fifo_wren[p] <= req_wren[owner[p]];
          // An aborting owner never closes the frame.
          fifo_del[p]  <= req_del[owner[p]] & req_wren[owner[p]] & req_valid[owner[p]];
        end else begin
          fifo_wren[p] <= 1'b0;
          fifo_del[p]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_phy_tx_fifo_arbiter.sv
// Scoreboard bench for phy_tx_fifo_arbiter with a lock-table reference model.
module tb_phy_tx_fifo_arbiter;

  localparam int NR = 5;
  localparam int NP = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid, req_wren, req_del, req_grant, req_afull;
  logic [NR*NP-1:0] req_port;
  logic [NR*8-1:0] req_din;
  logic [NP*8-1:0] fifo_din;
  logic [NP-1:0]   fifo_wren, fifo_del, fifo_afull;
  logic            err_abort;

  always #5 clk = ~clk;

  phy_tx_fifo_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_port   (req_port),
    .req_grant  (req_grant),
    .req_din    (req_din),
    .req_wren   (req_wren),
    .req_del    (req_del),
    .req_afull  (req_afull),
    .fifo_din   (fifo_din),
    .fifo_wren  (fifo_wren),
    .fifo_del   (fifo_del),
    .fifo_afull (fifo_afull),
    .err_abort  (err_abort)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         port;
    logic [7:0] din;
    logic       del;
  } exp_t;
  exp_t sbq[$];

  // reference lock table
  bit [NP-1:0] m_busy;
  int          m_owner [NP];
  bit [NR-1:0] m_grant;
  int          m_ptr;
  bit          m_abort;

  int          order[$];
  bit [3:0]    pm [NR];
  bit          pv [NR];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int r, input bit v, input bit [3:0] m, input bit w,
                         input bit d, input bit [7:0] din);
    req_valid[r]          = v;
    req_port[r*NP +: NP]  = m;
    req_wren[r]           = w;
    req_del[r]            = d;
    req_din[r*8 +: 8]     = din;
  endtask

  task automatic idle_all();
    for (int r = 0; r < NR; r++) set_req(r, 1'b0, 4'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Predicts the effect of the coming clock edge from the current inputs.
  task automatic model_edge();
    bit [NR-1:0] rel;
    bit [NR-1:0] elig;
    bit [3:0]    mk;
    int          w, o, idx;
    if (rst) begin
      m_busy  = '0;
      m_grant = '0;
      m_ptr   = 0;
      m_abort = 1'b0;
      for (int p = 0; p < NP; p++) m_owner[p] = 0;
      sbq.delete();
      return;
    end
    for (int p = 0; p < NP; p++) begin
      if (m_busy[p]) begin
        o = m_owner[p];
        if (req_wren[o])
          sbq.push_back('{cyc + 1, p, req_din[o*8 +: 8], req_del[o] & req_valid[o]});
      end
    end
    rel     = '0;
    m_abort = 1'b0;
    for (int r = 0; r < NR; r++) begin
      if (m_grant[r] && !req_valid[r]) begin
        m_abort = 1'b1;
        rel[r]  = 1'b1;
      end
      if (m_grant[r] && req_wren[r] && req_del[r]) rel[r] = 1'b1;
      mk      = req_port[r*NP +: NP];
      elig[r] = req_valid[r] && !m_grant[r] && (mk != 0) && ((mk & m_busy) == 0);
    end
    w = -1;
`ifdef PHY_TX_ARB_CTRL_PRIO_EN
    if (elig[NR-1]) w = NR - 1;
`endif
    if (w < 0) begin
      for (int i = 0; i < NR; i++) begin
        idx = (m_ptr + i) % NR;
        if (w < 0 && elig[idx]) w = idx;
      end
      if (w >= 0) m_ptr = (w + 1) % NR;
    end
    for (int p = 0; p < NP; p++)
      if (m_busy[p] && rel[m_owner[p]]) m_busy[p] = 1'b0;
    m_grant = m_grant & ~rel;
    if (w >= 0) begin
      mk = req_port[w*NP +: NP];
      for (int p = 0; p < NP; p++) begin
        if (mk[p]) begin
          m_busy[p]  = 1'b1;
          m_owner[p] = w;
        end
      end
      m_grant[w] = 1'b1;
    end
  endtask

  task automatic step();
    bit [NR-1:0] prev;
    bit [NR-1:0] eaf;
    prev = req_grant;
    model_edge();
    @(negedge clk);
    #1;
    for (int r = 0; r < NR; r++)
      if (req_grant[r] === 1'b1 && prev[r] !== 1'b1) order.push_back(r);
    eaf = '0;
    for (int p = 0; p < NP; p++)
      if (m_busy[p] && fifo_afull[p]) eaf[m_owner[p]] = 1'b1;
    chk("grant", req_grant, m_grant);
    chk("err_abort", err_abort, m_abort);
    chk("busy", dut.busy, m_busy);
    chk("req_afull", req_afull, eaf);
  endtask

  // Byte-path monitor: every FIFO write must match the oldest expected write.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int p = 0; p < NP; p++) begin
        if (fifo_wren[p] === 1'b1) begin
          if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_extra: port %0d wrote %0h with nothing expected (cycle %0d)",
                     p, fifo_din[p*8 +: 8], cyc);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_port", p, e.port);
            chk("sb_cycle", cyc, e.cyc);
            chk("sb_din", fifo_din[p*8 +: 8], e.din);
            chk("sb_del", fifo_del[p], e.del);
          end
        end else if (fifo_del[p] !== 1'b0) begin
          checks++; errors++;
          $display("FAIL sb_del_no_wren: port %0d del=%b wren=%b (cycle %0d)",
                   p, fifo_del[p], fifo_wren[p], cyc);
        end
      end
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        checks++; errors++;
        $display("FAIL sb_missing: port %0d byte %0h due cycle %0d not written (cycle %0d)",
                 sbq[0].port, sbq[0].din, sbq[0].cyc, cyc);
        void'(sbq.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Requesters in 'who' ask for mask m; granted ones send single-byte frames.
  task automatic run_frames(input bit [NR-1:0] who, input bit [3:0] m, input int n);
    for (int k = 0; k < n; k++) begin
      for (int r = 0; r < NR; r++) begin
        if (who[r])
          set_req(r, 1'b1, m, m_grant[r], m_grant[r], 8'($urandom));
      end
      step();
    end
    idle_all();
    step();
  endtask

  initial begin
    bit [NR-1:0] exp_first;
    rst = 1'b1;
    fifo_afull = '0;
    idle_all();
    step();
    step();
    rst = 1'b0;
    chk("rst_fifo_wren", fifo_wren, 0);
    chk("rst_fifo_del", fifo_del, 0);
    chk("rst_fifo_din", fifo_din, 0);
    chk("rst_rr_ptr", dut.rr_ptr, 0);
    mon_en = 1'b1;

    // single request, three bytes
    set_req(0, 1, 4'b0001, 0, 0, 8'h00); step();
    chk("t1_grant", req_grant[0], 1'b1);
    set_req(0, 1, 4'b0001, 1, 0, 8'hAA); step();
    set_req(0, 1, 4'b0001, 1, 0, 8'hBB); step();
    set_req(0, 1, 4'b0001, 1, 1, 8'hCC); step();
    chk("t1_busy_clear", dut.busy[0], 1'b0);
    chk("t1_grant_drop", req_grant[0], 1'b0);
    idle_all(); step();

    // multicast waits for the overlapping lock
    set_req(1, 1, 4'b0010, 0, 0, 8'h00); step();
    chk("t2_r1_grant", req_grant[1], 1'b1);
    set_req(4, 1, 4'b0011, 0, 0, 8'h00);
    set_req(1, 1, 4'b0010, 1, 0, 8'h11); step();
    chk("t2_r4_blocked", req_grant[4], 1'b0);
    set_req(1, 1, 4'b0010, 1, 1, 8'h22); step();
    chk("t2_r4_same_cycle", req_grant[4], 1'b0);
    set_req(1, 0, 4'b0000, 0, 0, 8'h00); step();
    chk("t2_r4_grant", req_grant[4], 1'b1);
    set_req(4, 1, 4'b0011, 1, 0, 8'h44); step();
    set_req(4, 1, 4'b0011, 1, 1, 8'h55); step();
    idle_all(); step();

    // round-robin order
    do_reset();
    order.delete();
    run_frames(5'b01101, 4'b0100, 10);
    if (order.size() < 4) begin
      checks++; errors++;
      $display("FAIL rr_order: only %0d grants seen, required 4", order.size());
    end else begin
      chk("rr_order0", order[0], 0);
      chk("rr_order1", order[1], 2);
      chk("rr_order2", order[2], 3);
      chk("rr_order3", order[3], 0);
    end

    // control requester priority
    do_reset();
    set_req(0, 1, 4'b0001, 0, 0, 8'h00);
    set_req(4, 1, 4'b0001, 0, 0, 8'h00);
    step();
`ifdef PHY_TX_ARB_CTRL_PRIO_EN
    exp_first = 5'b10000;
`else
    exp_first = 5'b00001;
`endif
    chk("prio_first", req_grant, exp_first);
    run_frames(5'b10001, 4'b0001, 6);

    // abort without delimiter
    set_req(2, 1, 4'b1000, 0, 0, 8'h00); step();
    chk("ab_grant", req_grant[2], 1'b1);
    set_req(2, 1, 4'b1000, 1, 0, 8'h31); step();
    set_req(2, 1, 4'b1000, 1, 0, 8'h32); step();
    set_req(2, 0, 4'b1000, 0, 0, 8'h00); step();
    chk("ab_pulse", err_abort, 1'b1);
    chk("ab_port_free", dut.busy[3], 1'b0);
    idle_all(); step();
    chk("ab_pulse_end", err_abort, 1'b0);

    // backpressure, then reset mid-frame
    set_req(0, 1, 4'b0001, 0, 0, 8'h00); step();
    fifo_afull = 4'b0001;
    set_req(0, 1, 4'b0001, 1, 0, 8'h61);
    #1;
    chk("bp_afull0", req_afull[0], 1'b1);
    chk("bp_afull1", req_afull[1], 1'b0);
    step();
    set_req(0, 1, 4'b0001, 1, 0, 8'h62);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_grant", req_grant, 0);
    chk("rst_mid_wren", fifo_wren, 0);
    fifo_afull = '0;
    idle_all(); step();

    // randomized traffic
    for (int r = 0; r < NR; r++) begin pv[r] = 1'b0; pm[r] = '0; end
    for (int k = 0; k < 3000; k++) begin
      for (int r = 0; r < NR; r++) begin
        bit w;
        if (m_grant[r]) begin
          pv[r] = 1'b0;
          w = ($urandom % 3) != 0;
          set_req(r, ($urandom % 40) != 0,
                  (($urandom % 10) == 0) ? 4'($urandom) : req_port[r*NP +: NP],
                  w, w && (($urandom % 5) == 0), 8'($urandom));
        end else begin
          if (!pv[r] && ($urandom % 4) == 0) begin
            pv[r] = 1'b1;
            pm[r] = 4'($urandom);
          end else if (pv[r] && ($urandom % 20) == 0) begin
            pv[r] = 1'b0;
          end
          set_req(r, pv[r], pm[r], ($urandom % 8) == 0, 1'($urandom), 8'($urandom));
        end
      end
      fifo_afull = 4'($urandom);
      rst = (($urandom % 500) == 0);
      step();
    end
    rst = 1'b0;
    idle_all();
    fifo_afull = '0;
    for (int k = 0; k < 5; k++) step();
    chk("sb_drain", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phy_tx_fifo_arbiter.md
# phy_tx_fifo_arbiter

Frame-granular arbiter that shares the four PHY-TX FIFOs between the per-port forwarding engines and the control frame issuer. A requester names one or more destination ports as a one-hot or multi-hot mask. It receives an atomic lock on all of them and then streams bytes through this block's muxes. The lock is released on the frame's last byte (`del`). The block sits between the requesters and the PHY-TX FIFO write ports; no requester drives a FIFO directly.

## Interface
Parameters:
- `N_REQ`, 5: number of requesters. Index 0..3 are forwarding engines; index 4 is the control frame issuer.
- `N_PORT`, 4: number of PHY-TX FIFOs.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in N_REQ: requester wants the ports in `req_port`.
- `req_port` in N_REQ*N_PORT: destination mask; slice r is `[r*N_PORT +: N_PORT]`.
- `req_grant` out N_REQ: lock held; level signal.
- `req_din` in N_REQ*8: frame byte.
- `req_wren` in N_REQ: byte valid.
- `req_del` in N_REQ: last byte of frame; qualified by `req_wren`.
- `req_afull` out N_REQ: OR of `fifo_afull` over ports owned by the requester; 0 when not granted.
- `fifo_din` out N_PORT*8: byte to each PHY-TX FIFO.
- `fifo_wren` out N_PORT: write strobe per FIFO.
- `fifo_del` out N_PORT: frame delimiter per FIFO.
- `fifo_afull` in N_PORT: almost-full from each FIFO.
- `err_abort` out 1: one-cycle pulse when a granted requester drops `req_valid` before `del`.

## Operation
- Per-port state: `busy[p]`, plus an owner index (3 bits).
- A requester r is eligible when all of the following hold:
  - `req_valid[r]`
  - `req_grant[r]` is 0
  - `req_port[r]` is nonzero
  - `req_port[r] & busy` is 0
- A zero mask is never granted.
- At most one new grant per cycle. The winner is picked round-robin among eligible requesters, starting at pointer `rr_ptr`. After a grant, `rr_ptr` becomes winner+1 mod N_REQ.
- On grant: `busy` is set and owner is written for every port in the mask, and `req_grant[r]` rises. A partial grant never occurs: either every requested port is locked or none.
- While granted, `req_port[r]` must stay stable. Any change is ignored because the mask is latched at grant.
- Byte path: for each busy port p with owner o, the block registers `fifo_din[p]<=req_din[o]`, `fifo_wren[p]<=req_wren[o]`, `fifo_del[p]<=req_del[o]&req_wren[o]`. Ports that are not busy register `wren=0`, `del=0`, and `din` unchanged.
- Release: `req_wren[o] & req_del[o]` clears `busy` for the owned ports and drops `req_grant[o]` on the next edge.
- Abort: `req_valid[o]` low while granted releases the ports as above, pulses `err_abort`, and emits no `del`.
- Requesters must honour `req_afull`. The arbiter does not drop or stall bytes.

## Timing
- Reset values: `req_grant` 0, `busy` 0, `rr_ptr` 0, `fifo_wren` 0, `fifo_del` 0, `fifo_din` 0, `err_abort` 0.
- Grant latency: `req_valid` sampled at edge t gives `req_grant` high after edge t.
- Data latency: `req_wren` at edge t appears on `fifo_wren` after edge t, one cycle of latency.
- `req_afull` is combinational from `fifo_afull` and the owner state.
- Release at edge t: the freed ports are eligible for arbitration at edge t+1. The same requester may be re-granted at t+1 if it still requests.
- Release and a new grant on disjoint ports in the same cycle are both performed.
- If a release and a request for the same ports happen in the same cycle, the request waits one cycle; `busy` is evaluated before the release.
- `rst` asserted mid-frame clears all locks; no `del` is emitted. FIFO cleanup is the FIFO owner's responsibility.

## Configuration
- `PHY_TX_ARB_CTRL_PRIO_EN` defined: requester N_REQ-1 (control frame issuer), when eligible, wins over round-robin, and `rr_ptr` is not updated on its grant.
- Not defined: pure round-robin across all requesters.

## Structure
- Package `l2sw_pkg`: `N_REQ`, `N_PORT`, `BYTE_W`=8, `REQ_CTRL`=4, and the owner-index width.
- Sub-module `rr_arbiter`: inputs are the eligible vector and `rr_ptr`; outputs are a one-hot winner and a valid flag. It is purely combinational. Pointer update stays in the parent.

## Test plan
- Single request: r0 requests mask 0001 and sends 3 bytes AA, BB, CC, with del on CC. Expect `req_grant[0]` one cycle later, and `fifo_din[0]` AA/BB/CC with `fifo_del[0]` on CC, one cycle after each byte. Expect `busy[0]` clear after CC.
- Multicast atomicity: r1 holds 0010; r4 requests 0011. Expect r4 to stay ungranted until r1's del, then be granted the cycle after release. Expect ports 0 and 1 to both carry r4's bytes.
- Round-robin: r0, r2, r3 all request 0100 continuously, with 1-byte frames. Expect grant order r0, r2, r3, r0.
- Priority, with the macro defined: r0 and r4 both request 0001 with the port free. Expect r4 to be granted first. Without the macro, expect r0 first.
- Abort: r2 is granted on 1000 and drops `req_valid` after 2 bytes with no del. Expect an `err_abort` pulse, no `fifo_del[3]`, and port 3 free next cycle.
- Backpressure and reset: with r0 owning 0001, assert `fifo_afull[0]`. Expect `req_afull[0]`=1 and `req_afull[1]`=0. Then assert `rst` mid-frame. Expect all grants and `fifo_wren` at 0 after the edge.
